// File: rtl/reservation_station.sv
// Single reservation station: age-ordered entry store with completion-bus wakeup
// and oldest-ready issue into a valid/ready issue register.
module reservation_station #(
  parameter int unsigned ROBsize    = 8,
  parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
  parameter int unsigned RSdepth    = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            writeEn_i,
  input  logic [ROBsizeLog-1:0]           ROBTag_i,
  input  logic [ROBsizeLog-1:0]           ROBTag1_i,
  input  logic [ROBsizeLog-1:0]           ROBTag2_i,
  input  logic [64:0]                     ROBval1_i,
  input  logic [64:0]                     ROBval2_i,
  input  logic [9:0]                      commands_i,
  output logic                            stall_o,
  input  logic                            completionValid_i,
  input  logic [ROBsizeLog-1:0]           completionRSROBTag_i,
  input  logic [64:0]                     completionRSROBval_i,
  output logic                            issueValid_o,
  input  logic                            issueReady_i,
  output logic [ROBsizeLog-1:0]           issueROBTag_o,
  output logic [63:0]                     issueVal1_o,
  output logic [63:0]                     issueVal2_o,
  output logic [9:0]                      issueCommands_o,
  output logic [$clog2(RSdepth+1)-1:0]    count_o
);

  localparam int unsigned TW = ROBsizeLog;
  localparam int unsigned CW = $clog2(RSdepth + 1);
  localparam int unsigned IW = $clog2(RSdepth);
  localparam int unsigned VW = 64;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [TW-1:0] tag1;
    logic [VW-1:0] val1;
    logic [TW-1:0] tag2;
    logic [VW-1:0] val2;
    logic [9:0]    cmd;
  } rs_entry_t;

  // Bit 64 of every value bus is not part of the datapath.
  logic unused_val_msb;
  assign unused_val_msb = ^{ROBval1_i[64], ROBval2_i[64], completionRSROBval_i[64]};

  // Capture a completing value into any operand still waiting on that tag.
  function automatic rs_entry_t wake(input rs_entry_t e, input logic cv,
                                     input logic [TW-1:0] ct, input logic [VW-1:0] cval);
    rs_entry_t r;
    r = e;
    if (cv && (e.tag1 != '0) && (e.tag1 == ct)) begin
      r.tag1 = '0;
      r.val1 = cval;
    end
    if (cv && (e.tag2 != '0) && (e.tag2 == ct)) begin
      r.tag2 = '0;
      r.val2 = cval;
    end
    return r;
  endfunction

  logic [RSdepth-1:0] valid_q;
  rs_entry_t          ent_q [RSdepth];

  logic [RSdepth:0]   valid_x;
  rs_entry_t          ent_w [RSdepth+1];
  rs_entry_t          new_ent;
  logic [RSdepth-1:0] valid_d;
  rs_entry_t          ent_d [RSdepth];
  logic               cand_found;
  logic [IW-1:0]      cand_idx;
  logic               load;
  logic               wr;
  logic [CW-1:0]      surv_cnt;
  logic [CW-1:0]      count_d;

  // Candidate selection, wakeup, removal/compaction and append.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = RSdepth - 1; i >= 0; i--) begin
      if (valid_q[i] && (ent_q[i].tag1 == '0) && (ent_q[i].tag2 == '0)) begin
        cand_found = 1'b1;
        cand_idx   = IW'(i);
      end
    end

    load = cand_found && (!issueValid_o || issueReady_i);
    wr   = writeEn_i && !stall_o;

    valid_x[RSdepth] = 1'b0;
    ent_w[RSdepth]   = '0;
    for (int i = 0; i < RSdepth; i++) begin
      valid_x[i] = valid_q[i];
      ent_w[i]   = wake(ent_q[i], completionValid_i, completionRSROBTag_i,
                        completionRSROBval_i[VW-1:0]);
    end

    new_ent.tag  = ROBTag_i;
    new_ent.tag1 = ROBTag1_i;
    new_ent.val1 = ROBval1_i[VW-1:0];
    new_ent.tag2 = ROBTag2_i;
    new_ent.val2 = ROBval2_i[VW-1:0];
    new_ent.cmd  = commands_i;
    new_ent      = wake(new_ent, completionValid_i, completionRSROBTag_i,
                        completionRSROBval_i[VW-1:0]);

    surv_cnt = count_o - CW'(load);
    count_d  = surv_cnt + CW'(wr);

    for (int i = 0; i < RSdepth; i++) begin
      if (load && (IW'(i) >= cand_idx)) begin
        valid_d[i] = valid_x[i+1];
        ent_d[i]   = ent_w[i+1];
      end else begin
        valid_d[i] = valid_x[i];
        ent_d[i]   = ent_w[i];
      end
      if (wr && (CW'(i) == surv_cnt)) begin
        valid_d[i] = 1'b1;
        ent_d[i]   = new_ent;
      end
    end
  end

  // Entry store, occupancy and full flag.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= '0;
      count_o <= '0;
      stall_o <= 1'b0;
      for (int i = 0; i < RSdepth; i++) ent_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      count_o <= count_d;
      stall_o <= (count_d == CW'(RSdepth));
      for (int i = 0; i < RSdepth; i++) ent_q[i] <= ent_d[i];
    end
  end

  // Issue register: refills whenever empty or being consumed.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      issueValid_o    <= 1'b0;
      issueROBTag_o   <= '0;
      issueVal1_o     <= '0;
      issueVal2_o     <= '0;
      issueCommands_o <= '0;
    end else if (load) begin
      issueValid_o    <= 1'b1;
      issueROBTag_o   <= ent_q[cand_idx].tag;
      issueVal1_o     <= ent_q[cand_idx].val1;
      issueVal2_o     <= ent_q[cand_idx].val2;
      issueCommands_o <= ent_q[cand_idx].cmd;
    end else if (issueReady_i) begin
      issueValid_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed test of reservation_station: latency, wakeup, bypass, full/stall,
// back-pressure and asynchronous reset.
module tb_reservation_station;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        writeEn_i;
  logic [3:0]  ROBTag_i, ROBTag1_i, ROBTag2_i;
  logic [64:0] ROBval1_i, ROBval2_i;
  logic [9:0]  commands_i;
  logic        stall_o;
  logic        completionValid_i;
  logic [3:0]  completionRSROBTag_i;
  logic [64:0] completionRSROBval_i;
  logic        issueValid_o;
  logic        issueReady_i;
  logic [3:0]  issueROBTag_o;
  logic [63:0] issueVal1_o, issueVal2_o;
  logic [9:0]  issueCommands_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  reservation_station dut (
    .clk_i(clk_i), .reset_i(reset_i), .writeEn_i(writeEn_i),
    .ROBTag_i(ROBTag_i), .ROBTag1_i(ROBTag1_i), .ROBTag2_i(ROBTag2_i),
    .ROBval1_i(ROBval1_i), .ROBval2_i(ROBval2_i), .commands_i(commands_i),
    .stall_o(stall_o), .completionValid_i(completionValid_i),
    .completionRSROBTag_i(completionRSROBTag_i), .completionRSROBval_i(completionRSROBval_i),
    .issueValid_o(issueValid_o), .issueReady_i(issueReady_i),
    .issueROBTag_o(issueROBTag_o), .issueVal1_o(issueVal1_o), .issueVal2_o(issueVal2_o),
    .issueCommands_o(issueCommands_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic put(input logic [3:0] t, input logic [3:0] t1, input logic [3:0] t2,
                     input logic [63:0] v1, input logic [63:0] v2, input logic [9:0] c);
    writeEn_i  = 1'b1;
    ROBTag_i   = t;
    ROBTag1_i  = t1;
    ROBTag2_i  = t2;
    ROBval1_i  = {1'b0, v1};
    ROBval2_i  = {1'b0, v2};
    commands_i = c;
  endtask

  task automatic comp(input logic [3:0] t, input logic [63:0] v);
    completionValid_i    = 1'b1;
    completionRSROBTag_i = t;
    completionRSROBval_i = {1'b1, v};
  endtask

  initial begin
    reset_i = 1'b0;
    writeEn_i = 1'b0; ROBTag_i = '0; ROBTag1_i = '0; ROBTag2_i = '0;
    ROBval1_i = '0; ROBval2_i = '0; commands_i = '0;
    completionValid_i = 1'b0; completionRSROBTag_i = '0; completionRSROBval_i = '0;
    issueReady_i = 1'b0;
    tick(); tick();
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_ivalid", 64'(issueValid_o), 64'd0);
    chk("rst_ival1", issueVal1_o, 64'd0);
    chk("rst_itag", 64'(issueROBTag_o), 64'd0);
    reset_i = 1'b1;
    tick();

    // T1: ready op issues two edges after write
    issueReady_i = 1'b1;
    put(4'd3, 4'd0, 4'd0, 64'd5, 64'd7, 10'h012);
    tick();
    writeEn_i = 1'b0;
    chk("t1_count_after_write", 64'(count_o), 64'd1);
    chk("t1_ivalid_early", 64'(issueValid_o), 64'd0);
    tick();
    chk("t1_ivalid", 64'(issueValid_o), 64'd1);
    chk("t1_itag", 64'(issueROBTag_o), 64'd3);
    chk("t1_ival1", issueVal1_o, 64'd5);
    chk("t1_ival2", issueVal2_o, 64'd7);
    chk("t1_icmd", 64'(issueCommands_o), 64'h012);
    chk("t1_count_drained", 64'(count_o), 64'd0);
    tick();
    chk("t1_ivalid_clear", 64'(issueValid_o), 64'd0);

    // T2: pending operand woken by completion bus
    put(4'd4, 4'd2, 4'd0, 64'd0, 64'h22, 10'h155);
    tick();
    writeEn_i = 1'b0;
    tick();
    chk("t2_waiting", 64'(issueValid_o), 64'd0);
    chk("t2_count", 64'(count_o), 64'd1);
    comp(4'd2, 64'h99);
    tick();
    completionValid_i = 1'b0;
    chk("t2_not_yet", 64'(issueValid_o), 64'd0);
    tick();
    chk("t2_ivalid", 64'(issueValid_o), 64'd1);
    chk("t2_itag", 64'(issueROBTag_o), 64'd4);
    chk("t2_ival1", issueVal1_o, 64'h99);
    chk("t2_ival2", issueVal2_o, 64'h22);
    chk("t2_icmd", 64'(issueCommands_o), 64'h155);
    tick();

    // T3: same-cycle write and completion bypass
    put(4'd1, 4'd0, 4'd5, 64'h1, 64'hdead, 10'h0aa);
    comp(4'd5, 64'h11);
    tick();
    writeEn_i = 1'b0; completionValid_i = 1'b0;
    tick();
    chk("t3_ivalid", 64'(issueValid_o), 64'd1);
    chk("t3_itag", 64'(issueROBTag_o), 64'd1);
    chk("t3_ival2", issueVal2_o, 64'h11);
    tick();
    chk("t3_clear", 64'(issueValid_o), 64'd0);

    // T4: fill, stall, drop, wake all, drain in age order
    for (int i = 1; i <= 4; i++) begin
      put(4'(i), 4'd6, 4'd0, 64'd0, 64'(i), 10'(i));
      tick();
    end
    writeEn_i = 1'b0;
    chk("t4_count_full", 64'(count_o), 64'd4);
    chk("t4_stall", 64'(stall_o), 64'd1);
    put(4'd7, 4'd0, 4'd0, 64'h77, 64'h77, 10'h077);
    tick();
    chk("t4_drop_count", 64'(count_o), 64'd4);
    chk("t4_drop_ivalid", 64'(issueValid_o), 64'd0);
    writeEn_i = 1'b0;
    comp(4'd6, 64'h66);
    tick();
    completionValid_i = 1'b0;
    chk("t4_wake_stall", 64'(stall_o), 64'd1);
    chk("t4_wake_ivalid", 64'(issueValid_o), 64'd0);
    // a write alongside the removal edge must still be refused
    put(4'd7, 4'd0, 4'd0, 64'h77, 64'h77, 10'h077);
    tick();
    writeEn_i = 1'b0;
    chk("t4_first_tag", 64'(issueROBTag_o), 64'd1);
    chk("t4_first_count", 64'(count_o), 64'd3);
    chk("t4_stall_clear", 64'(stall_o), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("t4_order_tag", 64'(issueROBTag_o), 64'(i));
      chk("t4_order_val2", issueVal2_o, 64'(i));
      chk("t4_order_val1", issueVal1_o, 64'h66);
    end
    chk("t4_empty", 64'(count_o), 64'd0);
    tick();
    chk("t4_no_dropped_op", 64'(issueValid_o), 64'd0);

    // T5: back-pressure holds the oldest op
    issueReady_i = 1'b0;
    put(4'd2, 4'd0, 4'd0, 64'h0a, 64'h0, 10'h001);
    tick();
    put(4'd3, 4'd0, 4'd0, 64'h0b, 64'h0, 10'h002);
    tick();
    writeEn_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_valid", 64'(issueValid_o), 64'd1);
      chk("t5_hold_tag", 64'(issueROBTag_o), 64'd2);
      chk("t5_hold_val1", issueVal1_o, 64'h0a);
      chk("t5_hold_count", 64'(count_o), 64'd1);
      tick();
    end
    issueReady_i = 1'b1;
    tick();
    chk("t5_second_tag", 64'(issueROBTag_o), 64'd3);
    chk("t5_second_val1", issueVal1_o, 64'h0b);
    chk("t5_second_count", 64'(count_o), 64'd0);
    tick();
    chk("t5_clear", 64'(issueValid_o), 64'd0);

    // T6: asynchronous reset with station and issue register full
    issueReady_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      put(4'(i), 4'd0, 4'd0, 64'(i), 64'(i), 10'(i));
      tick();
    end
    writeEn_i = 1'b0;
    chk("t6_pre_count", 64'(count_o), 64'd4);
    chk("t6_pre_stall", 64'(stall_o), 64'd1);
    chk("t6_pre_ivalid", 64'(issueValid_o), 64'd1);
    #2;
    reset_i = 1'b0;
    #1;
    chk("t6_count", 64'(count_o), 64'd0);
    chk("t6_ivalid", 64'(issueValid_o), 64'd0);
    chk("t6_stall", 64'(stall_o), 64'd0);
    chk("t6_itag", 64'(issueROBTag_o), 64'd0);
    tick();
    reset_i = 1'b1;
    tick();
    chk("t6_after_release", 64'(issueValid_o), 64'd0);
    chk("t6_after_count", 64'(count_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
